// File: rtl/m3ds_ahb_pkg.sv
// m3ds_ahb_pkg: shared AHB encodings, select indices and the default-slave
// state encoding for the peripheral-subsystem slave mux.
package m3ds_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Bit positions inside the data-phase select vector.
   localparam int SEL_BEETLE = 0;
   localparam int SEL_DEFSLV = 1;
   localparam int SEL_FPGA   = 2;
   localparam int SEL_MPS2   = 3;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

   // Collapse possibly multi-hot decoder selects to one-hot (or zero) with
   // priority beetle > fpga > mps2 > default slave.
   function automatic logic [3:0] resolve_sel(input logic beetle,
                                              input logic defslv,
                                              input logic fpga,
                                              input logic mps2);
      logic [3:0] s;
      s = '0;
      if (beetle)      s[SEL_BEETLE] = 1'b1;
      else if (fpga)   s[SEL_FPGA]   = 1'b1;
      else if (mps2)   s[SEL_MPS2]   = 1'b1;
      else if (defslv) s[SEL_DEFSLV] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/m3ds_ahb_default_slave.sv
// m3ds_ahb_default_slave: two-cycle AHB ERROR responder for unmapped
// NONSEQ/SEQ transfers, plus optional first-error address capture
// (enabled by defining M3DS_AHB_MUX_ERRCAPTURE_EN).
module m3ds_ahb_default_slave
   import m3ds_ahb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hready,
   input  logic [1:0]    htrans,
   input  logic [AW-1:0] haddr,
   input  logic          hsel,
   input  logic          err_clr,
   output logic          ready,
   output logic          resp,
   output logic          err_valid,
   output logic [AW-1:0] err_addr
);

   ds_state_e state, state_next;
   logic      qualify;
   logic      start_err;

   // An accepted NONSEQ/SEQ to the default slave; IDLE/BUSY get zero-wait OKAY.
   assign qualify   = hready & hsel & htrans[1];
   // Entry into the first error cycle from IDLE or ERR2.
   assign start_err = (state_next == DS_ERR1);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DS_IDLE;
      else        state <= state_next;
   end

   // Next-state and response decode.
   // NOTE: every output gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_next = state;
      ready      = 1'b1;
      resp       = HRESP_OKAY;
      unique case (state)
         DS_IDLE: begin
            if (qualify) state_next = DS_ERR1;
         end
         DS_ERR1: begin
            ready      = 1'b0;
            resp       = HRESP_ERROR;
            state_next = DS_ERR2;
         end
         DS_ERR2: begin
            resp       = HRESP_ERROR;
            state_next = qualify ? DS_ERR1 : DS_IDLE;
         end
         default: state_next = DS_IDLE;
      endcase
   end

`ifdef M3DS_AHB_MUX_ERRCAPTURE_EN
   // First-error capture; a clear request wins over a simultaneous capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
      end else if (err_clr) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
      end else if (start_err && !err_valid) begin
         err_valid <= 1'b1;
         err_addr  <= haddr;
      end
   end

   logic unused_bits;
   assign unused_bits = htrans[0];
`else
   assign err_valid = 1'b0;
   assign err_addr  = '0;

   logic unused_bits;
   assign unused_bits = ^{htrans[0], haddr, err_clr, start_err};
`endif

endmodule

// File: rtl/m3ds_ahb_slave_mux.sv
// m3ds_ahb_slave_mux: data-phase response stage behind the peripheral AHB
// decoder. Registers the address-phase selects and muxes HRDATA/HREADYOUT/
// HRESP from the selected slave. Optional error capture is enabled by
// defining M3DS_AHB_MUX_ERRCAPTURE_EN.
module m3ds_ahb_slave_mux
   import m3ds_ahb_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HREADY,
   input  logic [1:0]    HTRANS,
   input  logic [AW-1:0] HADDR,
   input  logic          BEETLE_HSEL_i,
   input  logic          DEFSLAVE_HSEL_i,
   input  logic          FPGA_HSEL_i,
   input  logic          MPS2_HSEL_i,
   input  logic [DW-1:0] BEETLE_HRDATA_i,
   input  logic          BEETLE_HREADYOUT_i,
   input  logic          BEETLE_HRESP_i,
   input  logic [DW-1:0] FPGA_HRDATA_i,
   input  logic          FPGA_HREADYOUT_i,
   input  logic          FPGA_HRESP_i,
   input  logic [DW-1:0] MPS2_HRDATA_i,
   input  logic          MPS2_HREADYOUT_i,
   input  logic          MPS2_HRESP_i,
   output logic [DW-1:0] HRDATA_o,
   output logic          HREADYOUT_o,
   output logic          HRESP_o,
   input  logic          ERR_CLR_i,
   output logic          DEFSLV_ERR_VALID_o,
   output logic [AW-1:0] DEFSLV_ERR_ADDR_o
);

   logic [3:0] sel_res;
   logic [3:0] dsel;
   logic       ds_ready;
   logic       ds_resp;

   assign sel_res = resolve_sel(BEETLE_HSEL_i, DEFSLAVE_HSEL_i, FPGA_HSEL_i, MPS2_HSEL_i);

   // Data-phase select: advances only when the bus accepts an address phase.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)    dsel <= '0;
      else if (HREADY) dsel <= sel_res;
   end

   m3ds_ahb_default_slave #(.AW(AW)) u_default_slave (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .hready    (HREADY),
      .htrans    (HTRANS),
      .haddr     (HADDR),
      .hsel      (DEFSLAVE_HSEL_i),
      .err_clr   (ERR_CLR_i),
      .ready     (ds_ready),
      .resp      (ds_resp),
      .err_valid (DEFSLV_ERR_VALID_o),
      .err_addr  (DEFSLV_ERR_ADDR_o)
   );

   // Response mux; with nothing selected the bus sees a zero-wait OKAY.
   always_comb begin
      HRDATA_o    = '0;
      HREADYOUT_o = 1'b1;
      HRESP_o     = HRESP_OKAY;
      if (dsel[SEL_BEETLE]) begin
         HRDATA_o    = BEETLE_HRDATA_i;
         HREADYOUT_o = BEETLE_HREADYOUT_i;
         HRESP_o     = BEETLE_HRESP_i;
      end else if (dsel[SEL_FPGA]) begin
         HRDATA_o    = FPGA_HRDATA_i;
         HREADYOUT_o = FPGA_HREADYOUT_i;
         HRESP_o     = FPGA_HRESP_i;
      end else if (dsel[SEL_MPS2]) begin
         HRDATA_o    = MPS2_HRDATA_i;
         HREADYOUT_o = MPS2_HREADYOUT_i;
         HRESP_o     = MPS2_HRESP_i;
      end else if (dsel[SEL_DEFSLV]) begin
         HREADYOUT_o = ds_ready;
         HRESP_o     = ds_resp;
      end
   end

endmodule

// File: tb/tb_m3ds_ahb_slave_mux.sv
// tb_m3ds_ahb_slave_mux: directed test-plan sequences followed by random
// traffic, scored against a transaction-level model of the slave mux.
module tb_m3ds_ahb_slave_mux;
   import m3ds_ahb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          HREADY;
   logic [1:0]    HTRANS;
   logic [AW-1:0] HADDR;
   logic          BEETLE_HSEL_i, DEFSLAVE_HSEL_i, FPGA_HSEL_i, MPS2_HSEL_i;
   logic [DW-1:0] BEETLE_HRDATA_i, FPGA_HRDATA_i, MPS2_HRDATA_i;
   logic          BEETLE_HREADYOUT_i, FPGA_HREADYOUT_i, MPS2_HREADYOUT_i;
   logic          BEETLE_HRESP_i, FPGA_HRESP_i, MPS2_HRESP_i;
   logic [DW-1:0] HRDATA_o;
   logic          HREADYOUT_o, HRESP_o;
   logic          ERR_CLR_i;
   logic          DEFSLV_ERR_VALID_o;
   logic [AW-1:0] DEFSLV_ERR_ADDR_o;

   m3ds_ahb_slave_mux #(.DW(DW), .AW(AW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS), .HADDR(HADDR),
      .BEETLE_HSEL_i(BEETLE_HSEL_i), .DEFSLAVE_HSEL_i(DEFSLAVE_HSEL_i),
      .FPGA_HSEL_i(FPGA_HSEL_i), .MPS2_HSEL_i(MPS2_HSEL_i),
      .BEETLE_HRDATA_i(BEETLE_HRDATA_i), .BEETLE_HREADYOUT_i(BEETLE_HREADYOUT_i),
      .BEETLE_HRESP_i(BEETLE_HRESP_i),
      .FPGA_HRDATA_i(FPGA_HRDATA_i), .FPGA_HREADYOUT_i(FPGA_HREADYOUT_i),
      .FPGA_HRESP_i(FPGA_HRESP_i),
      .MPS2_HRDATA_i(MPS2_HRDATA_i), .MPS2_HREADYOUT_i(MPS2_HREADYOUT_i),
      .MPS2_HRESP_i(MPS2_HRESP_i),
      .HRDATA_o(HRDATA_o), .HREADYOUT_o(HREADYOUT_o), .HRESP_o(HRESP_o),
      .ERR_CLR_i(ERR_CLR_i), .DEFSLV_ERR_VALID_o(DEFSLV_ERR_VALID_o),
      .DEFSLV_ERR_ADDR_o(DEFSLV_ERR_ADDR_o)
   );

   always #5 HCLK = ~HCLK;

   // One cycle of stimulus; slave response arrays are indexed by SEL_* (defslave slot unused).
   typedef struct packed {
      logic [1:0]       htrans;
      logic [31:0]      haddr;
      logic [3:0]       sel;
      logic [3:0][31:0] rdata;
      logic [3:0]       rdy;
      logic [3:0]       resp;
      logic             clr;
   } stim_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        ready;
      logic        resp;
      logic        valid;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state: selected slave index (-1 = none), error-cycle
   // position (0 = not erroring, 1 = first error cycle, 2 = second), capture record.
   int          m_dsel;
   int          m_err;
   logic        m_valid;
   logic [31:0] m_addr;
   logic        m_hready;
   stim_t       cur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int winner(input logic [3:0] sel);
      if (sel[SEL_BEETLE]) return SEL_BEETLE;
      if (sel[SEL_FPGA])   return SEL_FPGA;
      if (sel[SEL_MPS2])   return SEL_MPS2;
      if (sel[SEL_DEFSLV]) return SEL_DEFSLV;
      return -1;
   endfunction

   task automatic model_reset();
      m_dsel  = -1;
      m_err   = 0;
      m_valid = 1'b0;
      m_addr  = '0;
   endtask

   // Advance the model over one rising edge using the inputs that were applied.
   task automatic model_step();
      logic accepted_err;
      if (!HRESETn) begin
         model_reset();
         return;
      end
      accepted_err = m_hready && cur.sel[SEL_DEFSLV] && cur.htrans[1] && (m_err != 1);
`ifdef M3DS_AHB_MUX_ERRCAPTURE_EN
      if (cur.clr) begin
         m_valid = 1'b0;
         m_addr  = '0;
      end else if (accepted_err && !m_valid) begin
         m_valid = 1'b1;
         m_addr  = cur.haddr;
      end
`endif
      if (m_err == 1)        m_err = 2;
      else if (accepted_err) m_err = 1;
      else                   m_err = 0;
      if (m_hready) m_dsel = winner(cur.sel);
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.valid = m_valid;
      e.addr  = m_addr;
      if (m_dsel < 0) begin
         e.rdata = '0; e.ready = 1'b1; e.resp = 1'b0;
      end else if (m_dsel == SEL_DEFSLV) begin
         e.rdata = '0; e.ready = (m_err != 1); e.resp = (m_err != 0);
      end else begin
         e.rdata = cur.rdata[m_dsel];
         e.ready = cur.rdy[m_dsel];
         e.resp  = cur.resp[m_dsel];
      end
      return e;
   endfunction

   task automatic apply(input stim_t s);
      HTRANS             = s.htrans;
      HADDR              = s.haddr;
      BEETLE_HSEL_i      = s.sel[SEL_BEETLE];
      DEFSLAVE_HSEL_i    = s.sel[SEL_DEFSLV];
      FPGA_HSEL_i        = s.sel[SEL_FPGA];
      MPS2_HSEL_i        = s.sel[SEL_MPS2];
      BEETLE_HRDATA_i    = s.rdata[SEL_BEETLE];
      FPGA_HRDATA_i      = s.rdata[SEL_FPGA];
      MPS2_HRDATA_i      = s.rdata[SEL_MPS2];
      BEETLE_HREADYOUT_i = s.rdy[SEL_BEETLE];
      FPGA_HREADYOUT_i   = s.rdy[SEL_FPGA];
      MPS2_HREADYOUT_i   = s.rdy[SEL_MPS2];
      BEETLE_HRESP_i     = s.resp[SEL_BEETLE];
      FPGA_HRESP_i       = s.resp[SEL_FPGA];
      MPS2_HRESP_i       = s.resp[SEL_MPS2];
      ERR_CLR_i          = s.clr;
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s.htrans = HTRANS_IDLE;
      s.haddr  = $urandom;
      s.sel    = '0;
      for (int i = 0; i < 4; i++) s.rdata[i] = $urandom;
      s.rdy    = '1;
      s.resp   = '0;
      s.clr    = 1'b0;
      return s;
   endfunction

   function automatic stim_t xfer(input int idx, input logic [1:0] tr, input logic [31:0] a);
      stim_t s;
      s = idle_stim();
      s.sel[idx] = 1'b1;
      s.htrans   = tr;
      s.haddr    = a;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      int r;
      s = idle_stim();
      s.htrans = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      case (r)
         2, 3:    s.sel[SEL_BEETLE] = 1'b1;
         4, 5:    s.sel[SEL_DEFSLV] = 1'b1;
         6, 7:    s.sel[SEL_FPGA]   = 1'b1;
         8:       s.sel[SEL_MPS2]   = 1'b1;
         9: begin
            s.sel[SEL_BEETLE] = 1'($urandom_range(0, 1));
            s.sel[SEL_FPGA]   = 1'($urandom_range(0, 1));
            s.sel[SEL_MPS2]   = 1'($urandom_range(0, 1));
         end
         default: ;
      endcase
      for (int i = 0; i < 4; i++) begin
         s.rdy[i]  = ($urandom_range(0, 3) != 0);
         s.resp[i] = ($urandom_range(0, 7) == 0);
      end
      s.clr = ($urandom_range(0, 15) == 0);
      return s;
   endfunction

   // Drive one cycle: commit the edge to the model, apply new inputs, feed the
   // expected HREADYOUT back as bus HREADY, and queue the expected response.
   task automatic cycle(input stim_t s, input logic rst);
      exp_t e;
      @(posedge HCLK);
      model_step();
      #1;
      HRESETn = rst;
      if (!rst) model_reset();
      cur = s;
      apply(s);
      e = model_out();
      HREADY   = e.ready;
      m_hready = e.ready;
      exp_q.push_back(e);
   endtask

   // Monitor: compares the DUT response against the queued expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hrdata",    HRDATA_o,           e.rdata);
            check("hreadyout", 32'(HREADYOUT_o),   32'(e.ready));
            check("hresp",     32'(HRESP_o),       32'(e.resp));
            check("err_valid", 32'(DEFSLV_ERR_VALID_o), 32'(e.valid));
            check("err_addr",  DEFSLV_ERR_ADDR_o,  e.addr);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      HRESETn  = 1'b0;
      model_reset();
      cur      = idle_stim();
      apply(cur);
      HREADY   = 1'b1;
      m_hready = 1'b1;

      // Reset with random slave activity.
      repeat (3) cycle(rand_stim(), 1'b0);
      cycle(idle_stim(), 1'b1);

      // Beetle read with two wait states.
      cycle(xfer(SEL_BEETLE, HTRANS_NONSEQ, 32'h0000_1000), 1'b1);
      s = idle_stim();
      s.rdata[SEL_BEETLE] = 32'hCAFE_0001;
      s.rdy[SEL_BEETLE]   = 1'b0;
      cycle(s, 1'b1);
      cycle(s, 1'b1);
      s.rdy[SEL_BEETLE]   = 1'b1;
      cycle(s, 1'b1);
      cycle(idle_stim(), 1'b1);

      // Single default-slave error.
      cycle(xfer(SEL_DEFSLV, HTRANS_NONSEQ, 32'h5000_0000), 1'b1);
      repeat (3) cycle(idle_stim(), 1'b1);

      // Default-slave IDLE transfer: zero-wait OKAY, no capture change.
      cycle(xfer(SEL_DEFSLV, HTRANS_IDLE, 32'h5800_0000), 1'b1);
      repeat (2) cycle(idle_stim(), 1'b1);

      // Clear the record, then back-to-back errors.
      s = idle_stim();
      s.clr = 1'b1;
      cycle(s, 1'b1);
      cycle(xfer(SEL_DEFSLV, HTRANS_NONSEQ, 32'h5000_0000), 1'b1);
      cycle(xfer(SEL_DEFSLV, HTRANS_NONSEQ, 32'h6000_0000), 1'b1);
      cycle(xfer(SEL_DEFSLV, HTRANS_NONSEQ, 32'h6000_0000), 1'b1);
      repeat (3) cycle(idle_stim(), 1'b1);
      s = idle_stim();
      s.clr = 1'b1;
      cycle(s, 1'b1);
      cycle(idle_stim(), 1'b1);

      // Capture and clear in the same cycle: clear wins.
      s = xfer(SEL_DEFSLV, HTRANS_SEQ, 32'h6400_0000);
      s.clr = 1'b1;
      cycle(s, 1'b1);
      repeat (3) cycle(idle_stim(), 1'b1);

      // Async reset asserted during the first error cycle.
      cycle(xfer(SEL_DEFSLV, HTRANS_NONSEQ, 32'h7000_0000), 1'b1);
      cycle(idle_stim(), 1'b1);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b0;
      model_reset();
      #1;
      check("rst_hreadyout", 32'(HREADYOUT_o), 32'd1);
      check("rst_hresp",     32'(HRESP_o),     32'd0);
      check("rst_hrdata",    HRDATA_o,         32'd0);
      check("rst_err_valid", 32'(DEFSLV_ERR_VALID_o), 32'd0);
      check("rst_err_addr",  DEFSLV_ERR_ADDR_o, 32'd0);
      repeat (2) cycle(idle_stim(), 1'b0);
      cycle(idle_stim(), 1'b1);
      cycle(xfer(SEL_FPGA, HTRANS_NONSEQ, 32'h4000_0000), 1'b1);
      s = idle_stim();
      s.rdata[SEL_FPGA] = 32'h1234_5678;
      cycle(s, 1'b1);
      cycle(idle_stim(), 1'b1);

      // Random traffic.
      repeat (600) cycle(rand_stim(), 1'b1);
      cycle(idle_stim(), 1'b1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge HCLK);
      @(posedge HCLK);
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
